if_id_buffer: RTL and testbench
===============================

Name: if_id_buffer

Overview:
Decoupling buffer between the instruction-fetch stage and the ID stage register.
- Accepts fetch responses (PC, instruction, fetch-exception flag) with a valid/ready handshake.
- Presents exactly one instruction per cycle to ID.
- Holds that instruction while the ID-stage hazard unit deasserts ID_Wr, and parks further fetch returns in a small FIFO so no in-flight instruction is lost.
- Drains everything on a pipeline flush (branch redirect or exception).

Parameters:
DEPTH, 2, number of FIFO entries behind the ID register (power of two, ≥2)
NOP_INSTR, 32'h0000_0000, instruction word driven on ID_Instr when ID_Valid=0

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
IF_Valid  input  1  fetch response valid this cycle
IF_PC  input  32  PC of fetched instruction
IF_Instr  input  32  fetched instruction word
IF_ExcAdEL  input  1  fetch address error for this PC
IF_Ready  output  1  buffer can accept a fetch response this cycle
ID_Wr  input  1  1 = ID register may advance; 0 = stall, hold ID contents
ID_Flush  input  1  discard ID register, FIFO, and same-cycle fetch input
ID_Valid  output  1  ID register holds a real instruction
ID_PC  output  32  PC in ID register
ID_Instr  output  32  instruction in ID register (NOP_INSTR when invalid)
ID_ExcAdEL  output  1  fetch exception flag in ID register
FIFO_Count  output  $clog2(DEPTH+1)  current FIFO occupancy (debug/perf)

Behaviour:
- Reset (async, rst=1): ID_Valid=0, ID_PC=0, ID_Instr=NOP_INSTR, ID_ExcAdEL=0, FIFO empty, FIFO_Count=0, IF_Ready=1.
- Push handshake: a push occurs when IF_Valid && IF_Ready && !ID_Flush.
- IF_Ready is combinational and equals (FIFO_Count != DEPTH).
  - A full FIFO never accepts a push, even in a cycle that also pops.
- Priority per rising edge: ID_Flush > ID_Wr advance > hold.
- ID_Flush=1:
  - ID_Valid←0 and ID_Instr←NOP_INSTR.
  - FIFO pointers and count reset to empty.
  - Same-cycle IF input is dropped regardless of ID_Wr.
- ID_Wr=1, no flush: the ID register loads the oldest available instruction.
  - FIFO non-empty: load FIFO head and pop. A push in the same cycle is written at the tail, so count is unchanged.
  - FIFO empty and push: bypass, IF input loads directly into ID with 1-cycle latency from IF to ID. The FIFO is not written.
  - FIFO empty, no push: ID_Valid←0, ID_Instr←NOP_INSTR (bubble). ID_PC holds its old value.
- ID_Wr=0, no flush: the ID register holds all fields. A push writes the FIFO tail and count increments.
- Program order is strictly preserved: FIFO head is older than any same-cycle IF input.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is tracked separately, so full and empty are unambiguous.
- ID_ExcAdEL travels with its PC/instruction unchanged. The buffer does not act on exceptions.
- Reset asserted mid-operation discards all contents immediately. No partial state survives.

Decomposition:
- Shared package (CPU_Defines): typedef struct packed IF_ID_t {PC[31:0], Instr[31:0], ExcAdEL}, used for FIFO entries and the ID register.
- Constant NOP_INSTR default lives in the same package.
- One sub-module: fetch_fifo.
  - Parameterized on DEPTH and element type IF_ID_t.
  - Provides push/pop/flush, head, count, and full/empty.
  - Pop of an empty FIFO is ignored; push to a full FIFO is ignored.
- The top level holds the ID register and the bypass/priority mux.

Test Plan:
1. Reset, then IF_Valid=1 with PC=0xBFC00000, Instr=0x24080001, ID_Wr=1 → next cycle ID_Valid=1, ID_PC=0xBFC00000, ID_Instr=0x24080001, FIFO_Count=0.
2. ID holds A; ID_Wr=0 for 3 cycles while IF presents B, C, D:
   - B and C are accepted, FIFO_Count=2, IF_Ready=0 in the third cycle, D is not accepted.
   - ID stays A throughout.
   - Then ID_Wr=1 → ID shows B, then C, then D (once re-presented), in order.
3. FIFO full (count=2) and ID_Wr=1 with IF_Valid=1 → pop only, count becomes 1, IF input not consumed that cycle.
4. FIFO count=1 with ID_Wr=1 and push of E in the same cycle → ID loads the FIFO head, E enters FIFO, count stays 1, order preserved.
5. ID_Flush=1 with FIFO count=2, ID_Valid=1, IF_Valid=1 → next cycle ID_Valid=0, ID_Instr=0x00000000, count=0, IF_Ready=1, dropped IF input never appears at ID.
6. Entry with IF_ExcAdEL=1, PC=0x00000003, stalled 2 cycles in FIFO → appears at ID with ID_ExcAdEL=1 and ID_PC=0x00000003. Async rst pulse mid-stall clears everything without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the IF/ID decoupling buffer.
// The fetch payload struct is used both for FIFO entries and for the ID register.
package if_id_buffer_pkg;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc_adel;
   } if_id_t;

   // A bubble keeps the last PC but carries no instruction and no exception.
   function automatic if_id_t make_bubble(input if_id_t cur, input logic [31:0] nop);
      if_id_t b;
      b.pc       = cur.pc;
      b.instr    = nop;
      b.exc_adel = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-response / ID-stage bundle between the pipeline and the IF/ID buffer.
// master = pipeline side (fetch unit and hazard unit), slave = the buffer.
interface if_id_buffer_if #(
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             IF_Valid;
   logic [31:0]      IF_PC;
   logic [31:0]      IF_Instr;
   logic             IF_ExcAdEL;
   logic             IF_Ready;
   logic             ID_Wr;
   logic             ID_Flush;
   logic             ID_Valid;
   logic [31:0]      ID_PC;
   logic [31:0]      ID_Instr;
   logic             ID_ExcAdEL;
   logic [CNT_W-1:0] FIFO_Count;

   modport master (
      output IF_Valid, IF_PC, IF_Instr, IF_ExcAdEL, ID_Wr, ID_Flush,
      input  IF_Ready, ID_Valid, ID_PC, ID_Instr, ID_ExcAdEL, FIFO_Count
   );

   modport slave (
      input  IF_Valid, IF_PC, IF_Instr, IF_ExcAdEL, ID_Wr, ID_Flush,
      output IF_Ready, ID_Valid, ID_PC, ID_Instr, ID_ExcAdEL, FIFO_Count
   );

endinterface

// File: rtl/if_id_buffer_fetch_fifo.sv
// Small FIFO parking fetch returns while the ID register is stalled.
// Occupancy is tracked in its own counter so full and empty never alias.
module fetch_fifo
   import if_id_buffer_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   parameter  type         T     = if_id_t,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  T                 din,
   input  logic             pop,
   output T                 head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   T                 mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_s;
   logic             empty_s;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign empty_s   = (count_r == CNT_W'(0));
   assign do_push_s = push && !full_s;
   assign do_pop_s  = pop && !empty_s;

   // Storage, pointers and occupancy; flush empties without touching storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;
   assign full  = full_s;
   assign empty = empty_s;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling buffer: ID register plus a fetch FIFO behind it.
// Flush beats advance beats hold; the FIFO head is always older than same-cycle fetch input.
module if_id_buffer
   import if_id_buffer_pkg::*;
#(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input logic          clk,
   input logic          rst,
   if_id_buffer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   if_id_t           in_s;
   if_id_t           head_s;
   if_id_t           id_r;
   if_id_t           id_next_s;
   logic             id_valid_r;
   logic             id_valid_next_s;
   logic             push_s;
   logic             bypass_s;
   logic             fifo_push_s;
   logic             fifo_pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [CNT_W-1:0] fifo_count_s;

   assign in_s = '{pc: bus.IF_PC, instr: bus.IF_Instr, exc_adel: bus.IF_ExcAdEL};

   // A full FIFO refuses input even when the same cycle pops.
   assign bus.IF_Ready = !fifo_full_s;
   assign push_s       = bus.IF_Valid && !fifo_full_s && !bus.ID_Flush;
   assign bypass_s     = push_s && bus.ID_Wr && fifo_empty_s;
   assign fifo_push_s  = push_s && !bypass_s;
   assign fifo_pop_s   = !bus.ID_Flush && bus.ID_Wr && !fifo_empty_s;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (if_id_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.ID_Flush),
      .push  (fifo_push_s),
      .din   (in_s),
      .pop   (fifo_pop_s),
      .head  (head_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Next ID register contents: flush, then oldest available instruction, else hold.
   always_comb begin
      id_next_s       = id_r;
      id_valid_next_s = id_valid_r;
      if (bus.ID_Flush) begin
         id_valid_next_s = 1'b0;
         id_next_s       = make_bubble(id_r, NOP_INSTR);
      end else if (bus.ID_Wr) begin
         if (!fifo_empty_s) begin
            id_valid_next_s = 1'b1;
            id_next_s       = head_s;
         end else if (push_s) begin
            id_valid_next_s = 1'b1;
            id_next_s       = in_s;
         end else begin
            id_valid_next_s = 1'b0;
            id_next_s       = make_bubble(id_r, NOP_INSTR);
         end
      end else begin
         id_valid_next_s = id_valid_r;
         id_next_s       = id_r;
      end
   end

   // ID stage register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid_r <= 1'b0;
         id_r       <= '{pc: 32'h0000_0000, instr: NOP_INSTR, exc_adel: 1'b0};
      end else begin
         id_valid_r <= id_valid_next_s;
         id_r       <= id_next_s;
      end
   end

   assign bus.ID_Valid   = id_valid_r;
   assign bus.ID_PC      = id_r.pc;
   assign bus.ID_Instr   = id_r.instr;
   assign bus.ID_ExcAdEL = id_r.exc_adel;
   assign bus.FIFO_Count = fifo_count_s;

endmodule

// File: tb/tb_if_id_buffer.sv
// Table-driven bench for if_id_buffer with a scoreboard queue of accepted fetches.
module tb_if_id_buffer;
   import if_id_buffer_pkg::*;

   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
      logic        wr;
      logic        fl;
      logic        e_rdy;
      logic        e_val;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_exc;
      int          e_cnt;
      logic        chk_pc;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   vec_t   tbl[$];
   if_id_t sb_q[$];
   int     n_vec = 0;
   int     n_bad = 0;
   int     split;

   always #5 clk = ~clk;

   if_id_buffer_if #(.DEPTH(DEPTH)) bif ();

   if_id_buffer #(
      .DEPTH     (DEPTH),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic exc, input logic wr, input logic fl, input logic e_rdy,
                               input logic e_val, input logic [31:0] e_pc, input logic [31:0] e_instr,
                               input logic e_exc, input int e_cnt, input logic chk_pc);
      vec_t t;
      t.v = v; t.pc = pc; t.instr = instr; t.exc = exc; t.wr = wr; t.fl = fl;
      t.e_rdy = e_rdy; t.e_val = e_val; t.e_pc = e_pc; t.e_instr = e_instr;
      t.e_exc = e_exc; t.e_cnt = e_cnt; t.chk_pc = chk_pc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int idx);
      if_id_t exp_e;
      logic   acc;
      logic   deliver;
      bif.IF_Valid   = t.v;
      bif.IF_PC      = t.pc;
      bif.IF_Instr   = t.instr;
      bif.IF_ExcAdEL = t.exc;
      bif.ID_Wr      = t.wr;
      bif.ID_Flush   = t.fl;
      #2;
      chk($sformatf("v%0d if_ready", idx), 32'(bif.IF_Ready), 32'(t.e_rdy));
      chk($sformatf("v%0d sb_ready", idx), 32'(bif.IF_Ready), 32'(sb_q.size() != DEPTH));
      acc     = t.v && (sb_q.size() != DEPTH) && !t.fl;
      deliver = 1'b0;
      exp_e   = '0;
      if (t.fl) begin
         sb_q.delete();
      end else begin
         if (acc) sb_q.push_back('{pc: t.pc, instr: t.instr, exc_adel: t.exc});
         if (t.wr && sb_q.size() > 0) begin
            exp_e   = sb_q.pop_front();
            deliver = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d id_valid", idx), 32'(bif.ID_Valid), 32'(t.e_val));
      chk($sformatf("v%0d id_instr", idx), bif.ID_Instr, t.e_instr);
      chk($sformatf("v%0d fifo_count", idx), 32'(bif.FIFO_Count), t.e_cnt);
      if (t.chk_pc) chk($sformatf("v%0d id_pc", idx), bif.ID_PC, t.e_pc);
      if (t.e_val) chk($sformatf("v%0d id_exc", idx), 32'(bif.ID_ExcAdEL), 32'(t.e_exc));
      if (deliver) begin
         chk($sformatf("v%0d sb_valid", idx), 32'(bif.ID_Valid), 32'd1);
         chk($sformatf("v%0d sb_pc", idx), bif.ID_PC, exp_e.pc);
         chk($sformatf("v%0d sb_instr", idx), bif.ID_Instr, exp_e.instr);
         chk($sformatf("v%0d sb_exc", idx), 32'(bif.ID_ExcAdEL), 32'(exp_e.exc_adel));
      end else if (t.fl || t.wr) begin
         chk($sformatf("v%0d sb_bubble", idx), 32'(bif.ID_Valid), 32'd0);
      end
      chk($sformatf("v%0d sb_count", idx), 32'(bif.FIFO_Count), sb_q.size());
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " id_valid"}, 32'(bif.ID_Valid), 32'd0);
      chk({tag, " id_pc"}, bif.ID_PC, 32'h0000_0000);
      chk({tag, " id_instr"}, bif.ID_Instr, 32'h0000_0000);
      chk({tag, " id_exc"}, 32'(bif.ID_ExcAdEL), 32'd0);
      chk({tag, " fifo_count"}, 32'(bif.FIFO_Count), 32'd0);
      chk({tag, " if_ready"}, 32'(bif.IF_Ready), 32'd1);
   endtask

   initial begin
      // v, pc, instr, exc, wr, fl | rdy, val, pc, instr, exc, cnt, chk_pc
      tbl.push_back(mk(1, 32'hBFC0_0000, 32'h2408_0001, 0, 1, 0, 1, 1, 32'hBFC0_0000, 32'h2408_0001, 0, 0, 1));
      tbl.push_back(mk(1, 32'hBFC0_0004, 32'h2409_0002, 0, 0, 0, 1, 1, 32'hBFC0_0000, 32'h2408_0001, 0, 1, 1));
      tbl.push_back(mk(1, 32'hBFC0_0008, 32'h240A_0003, 0, 0, 0, 1, 1, 32'hBFC0_0000, 32'h2408_0001, 0, 2, 1));
      tbl.push_back(mk(1, 32'hBFC0_000C, 32'h240B_0004, 0, 0, 0, 0, 1, 32'hBFC0_0000, 32'h2408_0001, 0, 2, 1));
      tbl.push_back(mk(1, 32'hBFC0_000C, 32'h240B_0004, 0, 1, 0, 0, 1, 32'hBFC0_0004, 32'h2409_0002, 0, 1, 1));
      tbl.push_back(mk(1, 32'hBFC0_000C, 32'h240B_0004, 0, 1, 0, 1, 1, 32'hBFC0_0008, 32'h240A_0003, 0, 1, 1));
      tbl.push_back(mk(1, 32'hBFC0_0010, 32'h240C_0005, 0, 1, 0, 1, 1, 32'hBFC0_000C, 32'h240B_0004, 0, 1, 1));
      tbl.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 1, 1, 32'hBFC0_0010, 32'h240C_0005, 0, 0, 1));
      tbl.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 1, 0, 32'hBFC0_0010, 32'h0000_0000, 0, 0, 1));
      tbl.push_back(mk(1, 32'hBFC0_0014, 32'h240D_0006, 0, 1, 0, 1, 1, 32'hBFC0_0014, 32'h240D_0006, 0, 0, 1));
      tbl.push_back(mk(1, 32'hBFC0_0018, 32'h240E_0007, 0, 0, 0, 1, 1, 32'hBFC0_0014, 32'h240D_0006, 0, 1, 1));
      tbl.push_back(mk(1, 32'hBFC0_001C, 32'h240F_0008, 0, 0, 0, 1, 1, 32'hBFC0_0014, 32'h240D_0006, 0, 2, 1));
      tbl.push_back(mk(1, 32'hBFC0_0020, 32'h2410_0009, 0, 1, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0));
      tbl.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0));
      tbl.push_back(mk(1, 32'hBFC0_0060, 32'h2411_000A, 0, 0, 1, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0));
      tbl.push_back(mk(1, 32'h0000_0003, 32'h8C00_0000, 1, 0, 0, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0));
      tbl.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0));
      tbl.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 1, 0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0));
      tbl.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 1, 1, 32'h0000_0003, 32'h8C00_0000, 1, 0, 1));
      tbl.push_back(mk(1, 32'h0000_0040, 32'h8C00_0004, 0, 0, 0, 1, 1, 32'h0000_0003, 32'h8C00_0000, 1, 1, 1));
      tbl.push_back(mk(1, 32'h0000_0044, 32'h8C00_0008, 0, 0, 0, 1, 1, 32'h0000_0003, 32'h8C00_0000, 1, 2, 1));
      split = tbl.size();
      tbl.push_back(mk(1, 32'h0000_0050, 32'h1111_1111, 0, 1, 0, 1, 1, 32'h0000_0050, 32'h1111_1111, 0, 0, 1));
      tbl.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 0, 1, 0, 1, 0, 32'h0000_0050, 32'h0000_0000, 0, 0, 1));

      rst            = 1'b1;
      bif.IF_Valid   = 1'b0;
      bif.IF_PC      = 32'h0;
      bif.IF_Instr   = 32'h0;
      bif.IF_ExcAdEL = 1'b0;
      bif.ID_Wr      = 1'b0;
      bif.ID_Flush   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst = 1'b0;

      for (int i = 0; i < split; i++) apply(tbl[i], i);

      // Asynchronous reset pulse while two entries sit stalled in the FIFO.
      bif.IF_Valid = 1'b0;
      bif.ID_Wr    = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_reset_state("async_rst");
      #2;
      rst = 1'b0;
      sb_q.delete();
      @(posedge clk);
      #1;

      for (int i = split; i < tbl.size(); i++) apply(tbl[i], i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
